// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: adds two WIDTH-bit operands bit-serially, LSB first, by
// time-sharing one external full adder through the fa_* ports.
// Optional build macro SERIAL_ADD_SUB_EN adds a 'sub' input for a-b mode.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for an operand set, in_ready=1
// RUN   | one bit per clock through the external adder, busy=1
// DONE  | result held on sum/cout until out_ready, out_valid=1
module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADD_SUB_EN
    input  logic             sub,
`endif
    output logic             fa_a,
    output logic             fa_b,
    output logic             fa_cin,
    input  logic             fa_sum,
    input  logic             fa_carry,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t next_state;

    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic             c_reg;
    logic [CW-1:0]    cnt;
    logic             accept;
    logic             step;
    logic             last_bit;
`ifdef SERIAL_ADD_SUB_EN
    logic             sub_reg;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode and state-derived outputs, including the adder drive
    always_comb begin
        next_state = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b0;
        accept     = 1'b0;
        step       = 1'b0;
        last_bit   = 1'b0;
        fa_a       = 1'b0;
        fa_b       = 1'b0;
        fa_cin     = 1'b0;
        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept     = 1'b1;
                    next_state = RUN;
                end
            end
            RUN: begin
                busy     = 1'b1;
                step     = 1'b1;
                fa_a     = a_sh[0];
`ifdef SERIAL_ADD_SUB_EN
                // Subtraction is a + ~b + 1; the +1 comes from c_reg at load.
                fa_b     = b_sh[0] ^ sub_reg;
`else
                fa_b     = b_sh[0];
`endif
                fa_cin   = c_reg;
                last_bit = (cnt == LAST);
                if (last_bit) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Operand shift registers, carry, bit counter and result accumulation
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh    <= '0;
            b_sh    <= '0;
            c_reg   <= 1'b0;
            cnt     <= '0;
            sum     <= '0;
            cout    <= 1'b0;
`ifdef SERIAL_ADD_SUB_EN
            sub_reg <= 1'b0;
`endif
        end else if (accept) begin
            a_sh    <= a;
            b_sh    <= b;
            cnt     <= '0;
`ifdef SERIAL_ADD_SUB_EN
            sub_reg <= sub;
            c_reg   <= sub ? 1'b1 : cin;
`else
            c_reg   <= cin;
`endif
        end else if (step) begin
            sum   <= {fa_sum, sum[WIDTH-1:1]};
            a_sh  <= a_sh >> 1;
            b_sh  <= b_sh >> 1;
            c_reg <= fa_carry;
            cnt   <= cnt + CW'(1);
            if (last_bit) begin
                cout <= fa_carry;
            end
        end
    end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Bench for serial_add_ctrl (WIDTH=8) with a behavioural full adder on the
// fa_* ports and a queue of expected {cout,sum} results.
module tb_serial_add_ctrl;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
`ifdef SERIAL_ADD_SUB_EN
    logic         sub;
`endif
    logic         fa_a;
    logic         fa_b;
    logic         fa_cin;
    logic         fa_sum;
    logic         fa_carry;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         busy;

    int checks   = 0;
    int failures = 0;

    logic [W:0] exp_q[$];

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
`ifdef SERIAL_ADD_SUB_EN
        .sub       (sub),
`endif
        .fa_a      (fa_a),
        .fa_b      (fa_b),
        .fa_cin    (fa_cin),
        .fa_sum    (fa_sum),
        .fa_carry  (fa_carry),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .busy      (busy)
    );

    assign fa_sum   = fa_a ^ fa_b ^ fa_cin;
    assign fa_carry = (fa_a & fa_b) | (fa_a & fa_cin) | (fa_b & fa_cin);

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic c, input logic s);
        if (s) return {1'b0, x} + {1'b0, ~y} + (W+1)'(1);
        return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
    endfunction

    // Called at a negedge in IDLE; returns at the negedge after the accept edge.
    task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, input logic c,
                        input logic s);
        in_valid = 1'b1;
        a        = x;
        b        = y;
        cin      = c;
`ifdef SERIAL_ADD_SUB_EN
        sub      = s;
`endif
        check("send_in_ready", {31'd0, in_ready}, 32'd1);
        exp_q.push_back(model(x, y, c, s));
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(input string tag, output bit found);
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (out_valid) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check({tag, "_timeout"}, {31'd0, found}, 32'd1);
    endtask

    task automatic collect(input string tag);
        bit         found;
        logic [W:0] e;
        wait_valid(tag, found);
        if (found) begin
            check({tag, "_q_nonempty"}, {31'd0, exp_q.size() != 0}, 32'd1);
            e = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
            check(tag, {23'd0, cout, sum}, {23'd0, e});
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
            check({tag, "_back_idle"}, {30'd0, out_valid, in_ready}, 32'd1);
        end
    endtask

    initial begin
        bit             found;
        logic [W:0]     e;
        logic [W-1:0]   ta;
        logic [W-1:0]   tb;
        logic [W-1:0]   t5_a[4] = '{8'h12, 8'hF0, 8'h7F, 8'hAA};
        logic [W-1:0]   t5_b[4] = '{8'h34, 8'h0F, 8'h81, 8'h55};
        logic           t5_c[4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        int             k;
        int             results;
        int             busy_cnt;
        int             last_cyc;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
`ifdef SERIAL_ADD_SUB_EN
        sub       = 1'b0;
`endif

        // Reset state
        @(negedge clk);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_sum_cout", {23'd0, cout, sum}, 32'd0);
        check("rst_fa", {29'd0, fa_a, fa_b, fa_cin}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // T1: operand bits presented LSB first, result after W edges
        ta = 8'h5A;
        tb = 8'h33;
        send(ta, tb, 1'b0, 1'b0);
        check("t1_fa_cin0", {31'd0, fa_cin}, 32'd0);
        for (int i = 0; i < W; i++) begin
            check("t1_busy", {31'd0, busy}, 32'd1);
            check("t1_fa_ab", {30'd0, fa_a, fa_b}, {30'd0, ta[i], tb[i]});
            @(negedge clk);
        end
        check("t1_latency_valid", {31'd0, out_valid}, 32'd1);
        check("t1_fa_idle", {29'd0, fa_a, fa_b, fa_cin}, 32'd0);
        check("t1_expect_8d", {23'd0, exp_q[0]}, 32'h08D);
        collect("t1_result");

        // T2: carry propagation across all bits
        send(8'hFF, 8'h01, 1'b0, 1'b0);
        collect("t2_ff_p_01");
        send(8'hFF, 8'h00, 1'b1, 1'b0);
        collect("t2_ff_cin");

        // T3: stall in DONE with in_valid pulsing
        send(8'hC3, 8'h5C, 1'b1, 1'b0);
        wait_valid("t3_wait", found);
        if (found) begin
            e = exp_q[0];
            for (int i = 0; i < 5; i++) begin
                in_valid = 1'b1;
                a        = 8'hAA;
                b        = 8'hAA;
                check("t3_stall_hold", {23'd0, cout, sum}, {23'd0, e});
                check("t3_stall_flags", {29'd0, out_valid, in_ready, busy}, 32'd4);
                @(negedge clk);
            end
            in_valid = 1'b0;
        end
        collect("t3_result");
        for (int i = 0; i < 3; i++) begin
            check("t3_no_capture", {30'd0, busy, out_valid}, 32'd0);
            @(negedge clk);
        end

        // T4: reset in the middle of RUN
        send(8'h12, 8'h34, 1'b1, 1'b0);
        void'(exp_q.pop_back());
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("t4_rst_flags", {29'd0, in_ready, busy, out_valid}, 32'd4);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send(8'h01, 8'h01, 1'b0, 1'b0);
        collect("t4_after_rst");

        // T5: back-to-back operations, in_valid and out_ready held high
        out_ready = 1'b1;
        k         = 0;
        results   = 0;
        busy_cnt  = 0;
        last_cyc  = -1;
        for (int cyc = 0; cyc < 80 && results < 4; cyc++) begin
            if (busy) busy_cnt++;
            if (out_valid) begin
                e = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
                check("t5_result", {23'd0, cout, sum}, {23'd0, e});
                check("t5_busy_cycles", busy_cnt, 8);
                if (results > 0) check("t5_spacing", cyc - last_cyc, 10);
                last_cyc = cyc;
                busy_cnt = 0;
                results++;
            end
            if (in_ready) begin
                if (k < 4) begin
                    in_valid = 1'b1;
                    a        = t5_a[k];
                    b        = t5_b[k];
                    cin      = t5_c[k];
                    exp_q.push_back(model(t5_a[k], t5_b[k], t5_c[k], 1'b0));
                    k++;
                end else begin
                    in_valid = 1'b0;
                end
            end
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("t5_result_count", results, 4);
        @(negedge clk);

`ifdef SERIAL_ADD_SUB_EN
        // T6: subtraction mode
        send(8'h10, 8'h01, 1'b0, 1'b1);
        check("t6_expect", {23'd0, exp_q[0]}, 32'h10F);
        collect("t6_sub_no_borrow");
        send(8'h00, 8'h01, 1'b1, 1'b1);
        collect("t6_sub_borrow");
        send(8'h21, 8'h10, 1'b0, 1'b0);
        collect("t6_add_mode");
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
